// File: rtl/c2sm_arbiter_if.sv
// rtl/c2sm_arbiter_if.sv - requester, result and status signals of the c2sm_arbiter
// master = operand producers / result consumer side, slave = the arbiter itself.
interface c2sm_arbiter_if #(
  parameter int W     = 4,
  parameter int CNT_W = 8
);
  logic             req0;
  logic [W-1:0]     data0;
  logic             ack0;
  logic             req1;
  logic [W-1:0]     data1;
  logic             ack1;
  logic             out_valid;
  logic             out_ready;
  logic [W:0]       out_data;
  logic             out_src;
  logic             busy;
  logic [CNT_W-1:0] done_cnt;

  modport master (
    output req0, data0, req1, data1, out_ready,
    input  ack0, ack1, out_valid, out_data, out_src, busy, done_cnt
  );

  modport slave (
    input  req0, data0, req1, data1, out_ready,
    output ack0, ack1, out_valid, out_data, out_src, busy, done_cnt
  );
endinterface

// File: rtl/c2sm_arbiter.sv
// rtl/c2sm_arbiter.sv - round-robin shared two's-complement to sign-magnitude converter
// One operand in flight at a time: IDLE grants and captures, CONV converts, OUT waits for accept.
module c2sm_arbiter #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  c2sm_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             src_q, src_d;
  logic [W-1:0]     opnd_q, opnd_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             valid_q, valid_d;
  logic [W:0]       data_q, data_d;
  logic             osrc_q, osrc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic gnt_any;
  logic gnt_idx;
  logic accept;

  // Minimum negative value negates to itself, which is exactly the 2^(W-1) magnitude wanted.
  function automatic logic [W:0] to_sm(input logic [W-1:0] x);
    logic [W-1:0] mag;
    mag = x[W-1] ? (~x + W'(1)) : x;
    return {x[W-1], mag};
  endfunction

  always_comb begin
    gnt_any = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      gnt_idx = ~last_q;
    end else begin
      gnt_idx = bus.req1;
    end
  end

  assign accept = valid_q & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (gnt_any) state_d = S_CONV;
      S_CONV: state_d = S_OUT;
      S_OUT:  if (accept) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    last_d  = last_q;
    src_d   = src_q;
    opnd_d  = opnd_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    valid_d = valid_q;
    data_d  = data_q;
    osrc_d  = osrc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          src_d  = gnt_idx;
          opnd_d = gnt_idx ? bus.data1 : bus.data0;
          last_d = gnt_idx;
          ack0_d = ~gnt_idx;
          ack1_d = gnt_idx;
        end
      end
      S_CONV: begin
        data_d  = to_sm(opnd_q);
        osrc_d  = src_q;
        valid_d = 1'b1;
      end
      S_OUT: begin
        if (accept) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= 1'b1;
      src_q   <= 1'b0;
      opnd_q  <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      osrc_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      last_q  <= last_d;
      src_q   <= src_d;
      opnd_q  <= opnd_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      osrc_q  <= osrc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_src   = osrc_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done_cnt  = cnt_q;

endmodule

// File: tb/tb_c2sm_arbiter.sv
// tb/tb_c2sm_arbiter.sv - directed table-driven bench for c2sm_arbiter
// A second instance with a 2-bit counter mirrors the main stimulus to observe counter wrap.
module tb_c2sm_arbiter;

  logic clk;
  logic rst;

  c2sm_arbiter_if #(.W(4), .CNT_W(8)) bm ();
  c2sm_arbiter_if #(.W(4), .CNT_W(2)) bw ();

  c2sm_arbiter #(.W(4), .CNT_W(8)) u_dut (.clk(clk), .rst(rst), .bus(bm.slave));
  c2sm_arbiter #(.W(4), .CNT_W(2)) u_wrap (.clk(clk), .rst(rst), .bus(bw.slave));

  assign bw.req0      = bm.req0;
  assign bw.data0     = bm.data0;
  assign bw.req1      = bm.req1;
  assign bw.data1     = bm.data1;
  assign bw.out_ready = bm.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       sel;
    logic [3:0] d;
    logic [4:0] exp;
  } vec_t;

  vec_t       vecs[17];
  int         n_cmp;
  int         n_err;
  logic [7:0] exp_cnt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_conv(input logic sel, input logic [3:0] d, input logic [4:0] exp, input string tag);
    bm.out_ready = 1'b1;
    if (sel) begin
      bm.req1 = 1'b1; bm.data1 = d;
    end else begin
      bm.req0 = 1'b1; bm.data0 = d;
    end
    step();
    chk({tag, " ack0"}, 32'(bm.ack0), 32'(!sel));
    chk({tag, " ack1"}, 32'(bm.ack1), 32'(sel));
    chk({tag, " busy"}, 32'(bm.busy), 32'd1);
    bm.req0 = 1'b0;
    bm.req1 = 1'b0;
    step();
    chk({tag, " ack clear"}, 32'({bm.ack0, bm.ack1}), 32'd0);
    chk({tag, " valid"}, 32'(bm.out_valid), 32'd1);
    chk({tag, " data"}, 32'(bm.out_data), 32'(exp));
    chk({tag, " src"}, 32'(bm.out_src), 32'(sel));
    step();
    exp_cnt++;
    chk({tag, " valid drop"}, 32'(bm.out_valid), 32'd0);
    chk({tag, " cnt"}, 32'(bm.done_cnt), 32'(exp_cnt));
    chk({tag, " idle"}, 32'(bm.busy), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ack0"}, 32'(bm.ack0), 32'd0);
    chk({tag, " ack1"}, 32'(bm.ack1), 32'd0);
    chk({tag, " valid"}, 32'(bm.out_valid), 32'd0);
    chk({tag, " data"}, 32'(bm.out_data), 32'd0);
    chk({tag, " src"}, 32'(bm.out_src), 32'd0);
    chk({tag, " busy"}, 32'(bm.busy), 32'd0);
    chk({tag, " cnt"}, 32'(bm.done_cnt), 32'd0);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    exp_cnt = 8'd0;

    vecs[0]  = '{1'b0, 4'b1011, 5'b10101};
    vecs[1]  = '{1'b1, 4'b0000, 5'b00000};
    vecs[2]  = '{1'b1, 4'b0001, 5'b00001};
    vecs[3]  = '{1'b1, 4'b0010, 5'b00010};
    vecs[4]  = '{1'b1, 4'b0011, 5'b00011};
    vecs[5]  = '{1'b1, 4'b0100, 5'b00100};
    vecs[6]  = '{1'b1, 4'b0101, 5'b00101};
    vecs[7]  = '{1'b1, 4'b0110, 5'b00110};
    vecs[8]  = '{1'b1, 4'b0111, 5'b00111};
    vecs[9]  = '{1'b1, 4'b1000, 5'b11000};
    vecs[10] = '{1'b1, 4'b1001, 5'b10111};
    vecs[11] = '{1'b1, 4'b1010, 5'b10110};
    vecs[12] = '{1'b1, 4'b1011, 5'b10101};
    vecs[13] = '{1'b1, 4'b1100, 5'b10100};
    vecs[14] = '{1'b1, 4'b1101, 5'b10011};
    vecs[15] = '{1'b1, 4'b1110, 5'b10010};
    vecs[16] = '{1'b1, 4'b1111, 5'b10001};

    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bm.req0      = 1'($urandom);
      bm.req1      = 1'($urandom);
      bm.data0     = 4'($urandom);
      bm.data1     = 4'($urandom);
      bm.out_ready = 1'($urandom);
      step();
    end
    chk_zero("reset");
    bm.req0 = 1'b0;
    bm.req1 = 1'b0;
    bm.out_ready = 1'b0;
    rst = 1'b0;
    step();
    step();
    chk_zero("post reset idle");

    // Single conversion via requester 0, then full sweep via requester 1
    for (int i = 0; i < 17; i++) begin
      do_conv(vecs[i].sel, vecs[i].d, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Round-robin with both requests held high
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 8'd0;
    bm.out_ready = 1'b1;
    bm.data0 = 4'b0010;
    bm.data1 = 4'b1110;
    bm.req0 = 1'b1;
    bm.req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rr%0d ack0", k), 32'(bm.ack0), 32'(k % 2 == 0));
      chk($sformatf("rr%0d ack1", k), 32'(bm.ack1), 32'(k % 2 == 1));
      step();
      chk($sformatf("rr%0d valid", k), 32'(bm.out_valid), 32'd1);
      chk($sformatf("rr%0d src", k), 32'(bm.out_src), 32'(k % 2));
      chk($sformatf("rr%0d data", k), 32'(bm.out_data), (k % 2 == 0) ? 32'h02 : 32'h12);
      step();
      chk($sformatf("rr%0d valid drop", k), 32'(bm.out_valid), 32'd0);
    end
    bm.req0 = 1'b0;
    bm.req1 = 1'b0;
    chk("rr cnt", 32'(bm.done_cnt), 32'd4);
    exp_cnt = 8'd4;

    // Backpressure in OUT with req1 pending
    bm.req0 = 1'b1; bm.data0 = 4'b0101;
    bm.req1 = 1'b1; bm.data1 = 4'b1001;
    bm.out_ready = 1'b0;
    step();
    chk("bp ack0", 32'(bm.ack0), 32'd1);
    bm.req0 = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp%0d hold", i),
          32'({bm.out_valid, bm.out_data, bm.out_src, bm.busy, bm.ack1}),
          32'({1'b1, 5'b00101, 1'b0, 1'b1, 1'b0}));
      step();
    end
    bm.out_ready = 1'b1;
    step();
    exp_cnt++;
    chk("bp accept valid", 32'(bm.out_valid), 32'd0);
    chk("bp accept cnt", 32'(bm.done_cnt), 32'(exp_cnt));
    step();
    chk("bp ack1 next idle", 32'(bm.ack1), 32'd1);
    bm.req1 = 1'b0;
    step();
    chk("bp req1 result", 32'({bm.out_valid, bm.out_data, bm.out_src}), 32'({1'b1, 5'b10111, 1'b1}));
    step();
    exp_cnt++;
    chk("bp req1 cnt", 32'(bm.done_cnt), 32'(exp_cnt));

    // Reset during CONV discards the operand
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 8'd0;
    bm.req0 = 1'b1; bm.data0 = 4'b0111;
    step();
    chk("midrst ack0", 32'(bm.ack0), 32'd1);
    bm.req0 = 1'b0;
    rst = 1'b1;
    step();
    chk_zero("midrst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("midrst gone%0d", i), 32'({bm.out_valid, bm.busy}), 32'd0);
    end

    // Counter wrap on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      do_conv(1'b0, 4'(i), 5'(i), $sformatf("wrap%0d", i));
    end
    chk("wrap cnt2", 32'(bw.done_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/c2sm_arbiter.md
# c2sm_arbiter

Shared two's-complement to sign-magnitude conversion unit with round-robin arbitration between two requesters. Each requester presents a W-bit two's-complement operand with a request/acknowledge handshake. The block captures one operand at a time, converts it to (W+1)-bit sign-magnitude, and presents the result on a valid/ready output port tagged with the source index. It sits between the operand producers and any consumer of sign-magnitude values, and keeps a count of completed conversions.

## Interface
- W, 4, operand width in bits (W >= 2); result width is W+1.
- CNT_W, 8, width of the completed-conversion counter.

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0  in  1  requester 0 request; held high with stable data0 until ack0 is seen
- data0  in  W  requester 0 operand, two's complement
- ack0  out  1  one-cycle pulse: data0 has been captured
- req1  in  1  requester 1 request, same rules as req0
- data1  in  W  requester 1 operand
- ack1  out  1  one-cycle pulse: data1 has been captured
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result when high together with out_valid
- out_data  out  W+1  bit W = sign, bits W-1:0 = magnitude
- out_src  out  1  index of the requester that supplied the result
- busy  out  1  high in any state other than IDLE
- done_cnt  out  CNT_W  number of accepted results, wraps modulo 2^CNT_W

## Operation
- FSM states are IDLE, CONV and OUT.
- **IDLE**: If neither request is high, the FSM stays in IDLE. If exactly one request is high, that requester is granted. If both are high, the requester not granted last time is granted. The last-grant register resets to 1, so requester 0 wins the first tie.
  - On grant, the block captures the winner's data and index, registers the matching ack high, updates last-grant, and moves to CONV.
- **CONV**: The block registers the converted result into out_data and the captured index into out_src. It clears ack, sets out_valid, and moves to OUT.
- **OUT**: out_valid, out_data and out_src are held stable.
  - On out_valid && out_ready, the block clears out_valid, increments done_cnt, and moves to IDLE.
  - Requests are not sampled in CONV or OUT.
- **Conversion rules**:
  - sign = x[W-1].
  - mag = sign ? (~x + 1) truncated to W bits : x.
  - Minimum value -2^(W-1) gives mag = 2^(W-1), which fits in W bits (e.g. W=4: 1000 -> 11000).
  - Zero always gives all-zero output. Negative zero is never produced.
- **Requester rules**: A requester may drop req at any time before ack. A dropped request is simply not granted, and no ack is issued for it. After ack it must drop req, or the request is treated as a new one once the FSM returns to IDLE.
- **Reset values**: ack0 = ack1 = 0, out_valid = 0, out_data = 0, out_src = 0, busy = 0, done_cnt = 0, state = IDLE, last-grant = 1.
- **Reset mid-operation**: rst has priority over every transition. A captured but unconverted operand or an unaccepted result is discarded. No ack is emitted, and done_cnt is not incremented.

## Timing
- Edge E0: in IDLE, req sampled high; capture happens and ackN is high during E0..E1.
- Edge E1: transition to OUT; out_valid is high from E1 on.
- Request-to-valid latency is 2 cycles. Ack is exactly one cycle wide.
- The minimum period per conversion is 3 cycles (IDLE, CONV, OUT) with out_ready held high.
- out_ready high during CONV has no effect. Acceptance only occurs in OUT.
- Backpressure stalls the block in OUT indefinitely, with outputs frozen and no acks issued.
- done_cnt updates at the same edge out_valid falls. It wraps from 2^CNT_W-1 to 0.
- busy = (state != IDLE), driven from state registers.

## Test plan
- **Reset**: hold rst 3 cycles with random inputs -> all outputs 0, state IDLE. After release with no requests, outputs stay 0.
- **Single conversion**: W=4, req0=1, data0=4'b1011, out_ready=1.
  - ack0 is high for exactly one cycle after the first sampling edge.
  - Two cycles later out_valid=1, out_data=5'b10101, out_src=0.
  - done_cnt becomes 1 after the handshake.
- **Value sweep**: drive all 16 operands through req1. Expected results include 0111->00111, 0000->00000, 1111->10001, 1000->11000. out_src=1 throughout.
- **Round-robin**: req0 and req1 held high continuously, each re-requesting after its ack, out_ready=1.
  - Grant order is 0,1,0,1,...
  - One result every 3 cycles.
  - done_cnt is 4 after four results.
- **Backpressure**: out_ready=0 for 6 cycles while in OUT with req1 pending.
  - out_valid, out_data and out_src stay stable, busy=1, ack1=0.
  - Raising out_ready completes the handshake, then req1 is granted in the next IDLE cycle.
- **Reset mid-operation and counter wrap**:
  - Assert rst in CONV: the next cycle shows all outputs 0, and the discarded result never appears.
  - Separately, with CNT_W=2, five accepted results give done_cnt = 1.
